bubble_timing_gen: RTL
======================

BUBBLE_TIMING_GEN -- requirements
Module: bubble_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: master_clock cycles per internal tick (>=2).
REQ-002 SHALL have parameter OUT_DIV, default 6: master_clock cycles per clock_out half-period.
REQ-003 SHALL have parameter SYNC_STAGES, default 3: synchroniser depth for control inputs, in ticks.
REQ-004 SHALL have parameter ROT_LEN, default 120: ticks per full field rotation.
REQ-005 SHALL have parameters START_LEN, default 28, and STOP_LEN, default 123: ramp lengths in ticks.
REQ-006 SHALL have parameter CH, default 2: data-output clock channels; ROT_LEN divisible by CH.
REQ-007 SHALL have parameter POS_MOD, default 2053: rotation-position modulus; POS_W = clog2(POS_MOD).
REQ-008 master_clock  input  1  sole clock (48 MHz).
REQ-009 master_reset_n  input  1  asynchronous, active-low reset.
REQ-010 bubble_module_enable_n  input  1  high forces block idle.
REQ-011 bubble_shift_enable_n  input  1  low requests shifting.
REQ-012 replicator_enable_n  input  1  low enables replicator pulse.
REQ-013 bootloop_enable  input  1  high selects bootloop page.
REQ-014 clock_out  output  1  divided clock, 50 % duty.
REQ-015 tick  output  1  one-master_clock pulse per internal tick.
REQ-016 position_change  output  1  high at phases ROT_LEN-2 and ROT_LEN-1 in SHIFT.
REQ-017 position_latch  output  1  replicator pulse AND synchronised bootloop.
REQ-018 page_select  output  1  synchronised bootloop_enable.
REQ-019 bubble_access  output  1  high in START, SHIFT, STOP.
REQ-020 data_clock  output  CH  per-channel bubble data output clock.
REQ-021 position  output  POS_W  completed-rotation counter.

Function
REQ-022 Tick: free-running counter 0..CLK_DIV-1; tick high when counter = CLK_DIV-1; all state below advances only on tick (no derived clocks).
REQ-023 clock_out toggles every OUT_DIV master_clock cycles, independent of tick.
REQ-024 Inputs pass SYNC_STAGES tick-enabled flops; module disable ORs into shift/replicator, ANDs out bootloop, before stage 1.
REQ-025 FSM IDLE/START/SHIFT/STOP, ramp/phase counter cnt.
REQ-026 IDLE: cnt=0; shift requested -> START, cnt=0.
REQ-027 START: cnt increments; at cnt=START_LEN-1 -> SHIFT, cnt=0.
REQ-028 SHIFT: cnt wraps ROT_LEN-1 -> 0; at wrap, position increments modulo POS_MOD (POS_MOD-1 -> 0).
REQ-029 SHIFT with shift released: current rotation completes; at cnt=ROT_LEN-1 -> STOP, cnt=0, position still increments.
REQ-030 STOP: runs STOP_LEN ticks then IDLE; shift requests ignored until IDLE.
REQ-031 Synchronised module disable in any state -> IDLE next tick, cnt=0; position retained.
REQ-032 Replicator pulse: SHIFT, replicator enabled, cnt in 1..3.
REQ-033 data_clock[c] high in SHIFT for cnt in 4+c*ROT_LEN/CH .. 13+c*ROT_LEN/CH.
REQ-034 All status outputs registered, updating one master_clock after the tick edge.

Reset
REQ-035 On master_reset_n low: FSM IDLE, cnt/position/dividers 0, clock_out 1, synchronisers at idle (shift/replicator 1, bootloop 0), all other outputs 0.
REQ-036 Reset release mid-operation restarts from IDLE; no partial rotation resumes.

Structure
REQ-037 Shared package bubble_pkg holds FSM state enum and default phase constants (REP_START=1, DOUT_OFS=4, DOUT_LEN=10).
REQ-038 Synchroniser is sub-module bubble_sync (parametrised depth, width, reset value).

Verification
REQ-039 Reset, idle 200 cycles -> clock_out period 12 cycles, tick every 4, bubble_access 0.
REQ-040 Shift low 1 rotation then high -> bubble_access high 28+120+123 ticks, position 0->1.
REQ-041 Replicator low, bootloop high in SHIFT -> position_latch high cnt 1..3; data_clock[0] cnt 4..13, [1] cnt 64..73.
REQ-042 POS_MOD=4, 5 rotations -> position 1,2,3,0,1.
REQ-043 Module disable mid-SHIFT -> IDLE within SYNC_STAGES+1 ticks, outputs 0, position held.
REQ-044 Reset asserted mid-SHIFT -> all outputs at reset values same cycle; restart needs full START ramp.

Source files
------------

// File: rtl/bubble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bubble_pkg
// Purpose  : Shared FSM state type and default phase constants for the
//            bubble-memory timing generator.
// Revision : 1.0 - initial release
// ============================================================================
package bubble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } bubble_state_t;

    // Replicator pulse occupies phases REP_START .. REP_START+REP_LEN-1
    localparam int REP_START = 1;
    localparam int REP_LEN   = 3;

    // Data clock window per channel, offset by c*ROT_LEN/CH inside a rotation
    localparam int DOUT_OFS  = 4;
    localparam int DOUT_LEN  = 10;

endpackage
`default_nettype wire

// File: rtl/bubble_sync.sv
`default_nettype none
// ============================================================================
// Module   : bubble_sync
// Purpose  : Tick-enabled multi-stage synchroniser with a parametric reset value.
// Revision : 1.0 - initial release
// ============================================================================
module bubble_sync #(
    parameter int               DEPTH     = 3,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bubble_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : bubble_timing_gen
// Purpose  : Tick-based start/shift/stop sequencer and clock generation for a
//            magnetic-bubble memory module.
// Revision : 1.0 - initial release
// ============================================================================
module bubble_timing_gen
    import bubble_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int OUT_DIV     = 6,
    parameter int SYNC_STAGES = 3,
    parameter int ROT_LEN     = 120,
    parameter int START_LEN   = 28,
    parameter int STOP_LEN    = 123,
    parameter int CH          = 2,
    parameter int POS_MOD     = 2053,
    parameter int POS_W       = $clog2(POS_MOD)
) (
    input  logic             master_clock,
    input  logic             master_reset_n,
    input  logic             bubble_module_enable_n,
    input  logic             bubble_shift_enable_n,
    input  logic             replicator_enable_n,
    input  logic             bootloop_enable,
    output logic             clock_out,
    output logic             tick,
    output logic             position_change,
    output logic             position_latch,
    output logic             page_select,
    output logic             bubble_access,
    output logic [CH-1:0]    data_clock,
    output logic [POS_W-1:0] position
);

    localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_out_w   = (OUT_DIV > 1) ? $clog2(OUT_DIV) : 1;
    localparam int c_cnt_max = (START_LEN > ROT_LEN)
                             ? ((START_LEN > STOP_LEN) ? START_LEN : STOP_LEN)
                             : ((ROT_LEN > STOP_LEN) ? ROT_LEN : STOP_LEN);
    localparam int c_cnt_w   = $clog2(c_cnt_max);
    localparam int c_slot    = ROT_LEN / CH;

    // ------------------------------------------------------------------
    // Tick divider and free-running output clock divider
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] r_div_cnt;
    logic               r_tick;
    logic [c_out_w-1:0] r_out_cnt;
    logic               r_clock_out;

    // r_tick is set one cycle early so it is high exactly while the
    // divider sits at its terminal count.
    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_div_cnt <= (r_div_cnt == c_div_w'(CLK_DIV - 1)) ? '0 : r_div_cnt + c_div_w'(1);
            r_tick    <= (r_div_cnt == c_div_w'(CLK_DIV - 2));
        end
    end

    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            r_out_cnt   <= '0;
            r_clock_out <= 1'b1;
        end else if (r_out_cnt == c_out_w'(OUT_DIV - 1)) begin
            r_out_cnt   <= '0;
            r_clock_out <= ~r_clock_out;
        end else begin
            r_out_cnt   <= r_out_cnt + c_out_w'(1);
        end
    end

    // ------------------------------------------------------------------
    // Control input synchronisation; disable is folded in before stage 1
    // ------------------------------------------------------------------
    logic [3:0] w_sync_d;
    logic [3:0] w_sync_q;
    logic       w_dis_s;
    logic       w_shift_n_s;
    logic       w_rep_n_s;
    logic       w_boot_s;

    assign w_sync_d = {bubble_module_enable_n,
                       bubble_shift_enable_n | bubble_module_enable_n,
                       replicator_enable_n   | bubble_module_enable_n,
                       bootloop_enable       & ~bubble_module_enable_n};

    bubble_sync #(
        .DEPTH     (SYNC_STAGES),
        .WIDTH     (4),
        .RESET_VAL (4'b1110)
    ) u_sync (
        .clk   (master_clock),
        .rst_n (master_reset_n),
        .i_en  (r_tick),
        .i_d   (w_sync_d),
        .o_q   (w_sync_q)
    );

    assign {w_dis_s, w_shift_n_s, w_rep_n_s, w_boot_s} = w_sync_q;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    bubble_state_t      r_state;
    bubble_state_t      w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [POS_W-1:0]   r_position;
    logic [POS_W-1:0]   w_position_nxt;

    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_position <= '0;
        end else if (r_tick) begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_position <= w_position_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + c_cnt_w'(1);
        w_position_nxt = r_position;
        if (w_dis_s) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (!w_shift_n_s) begin
                        w_state_nxt = ST_START;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_cnt_w'(START_LEN - 1)) begin
                        w_state_nxt = ST_SHIFT;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_SHIFT: begin
                    // A released shift request only takes effect at the end of a rotation
                    if (r_cnt == c_cnt_w'(ROT_LEN - 1)) begin
                        w_cnt_nxt      = '0;
                        w_position_nxt = (r_position == POS_W'(POS_MOD - 1))
                                       ? '0 : r_position + POS_W'(1);
                        if (w_shift_n_s) begin
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_cnt_w'(STOP_LEN - 1)) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Phase decode
    // ------------------------------------------------------------------
    int          w_cnt_int;
    logic        w_in_shift;
    logic        w_access_d;
    logic        w_pos_change_d;
    logic        w_rep_d;
    logic        w_latch_d;
    logic [CH-1:0] w_dclk_d;

    assign w_cnt_int      = int'(r_cnt);
    assign w_in_shift     = (r_state == ST_SHIFT);
    assign w_access_d     = (r_state != ST_IDLE);
    assign w_pos_change_d = w_in_shift && (w_cnt_int >= ROT_LEN - 2);
    assign w_rep_d        = w_in_shift && !w_rep_n_s
                         && (w_cnt_int >= REP_START) && (w_cnt_int < REP_START + REP_LEN);
    assign w_latch_d      = w_rep_d && w_boot_s;

    for (genvar c = 0; c < CH; c++) begin : g_dclk
        localparam int c_lo = DOUT_OFS + c * c_slot;
        assign w_dclk_d[c] = w_in_shift && (w_cnt_int >= c_lo) && (w_cnt_int < c_lo + DOUT_LEN);
    end

    // ------------------------------------------------------------------
    // Registered status outputs
    // ------------------------------------------------------------------
    logic             r_access;
    logic             r_pos_change;
    logic             r_pos_latch;
    logic             r_page;
    logic [CH-1:0]    r_dclk;
    logic [POS_W-1:0] r_position_q;

    always_ff @(posedge master_clock or negedge master_reset_n) begin
        if (!master_reset_n) begin
            r_access     <= 1'b0;
            r_pos_change <= 1'b0;
            r_pos_latch  <= 1'b0;
            r_page       <= 1'b0;
            r_dclk       <= '0;
            r_position_q <= '0;
        end else begin
            r_access     <= w_access_d;
            r_pos_change <= w_pos_change_d;
            r_pos_latch  <= w_latch_d;
            r_page       <= w_boot_s;
            r_dclk       <= w_dclk_d;
            r_position_q <= r_position;
        end
    end

    assign clock_out       = r_clock_out;
    assign tick            = r_tick;
    assign position_change = r_pos_change;
    assign position_latch  = r_pos_latch;
    assign page_select     = r_page;
    assign bubble_access   = r_access;
    assign data_clock      = r_dclk;
    assign position        = r_position_q;

endmodule
`default_nettype wire
